datapath_pipe: RTL and testbench
================================

Name: datapath_pipe

Overview:
Parametrised successor to the 16-register ARC datapath. It holds a register file of configurable depth with two fixed constant registers, two read ports, and one registered write-back stage with read bypass. It also contains an ARC-compatible 4-bit ALU, a latched condition-code register (PSR), and a memory-read wait handshake that stalls write-back. It sits between the microcontroller (MIR fields, IR-derived addresses, ALU op) and the memory interface.

Parameters:
DATAWIDTH_BUS, 32, data path width (≥16).
NUM_REGS, 38, total registers including r0/r1 (≤2^DATAWIDTH_REG_ADDR).
DATAWIDTH_REG_ADDR, 6, register address width.
DATAWIDTH_ALU_SELECTION, 4, ALU opcode width.
FIXED_R1_VALUE, 1, constant held by r1 (r0 is always 0).

Ports:
DATAPATH_PIPE_CLOCK_50  in  1  clock, rising edge
DATAPATH_PIPE_ResetInHigh_In  in  1  synchronous active-high reset
DATAPATH_PIPE_DirA_InBus / DirB_InBus / DirC_InBus  in  DATAWIDTH_REG_ADDR each  MIR addresses
DATAPATH_PIPE_IRDirA_InBus / IRDirB_InBus / IRDirC_InBus  in  DATAWIDTH_REG_ADDR each  IR-field addresses (rs1/rs2/rd)
DATAPATH_PIPE_SelectA_In / SelectB_In / SelectC_In  in  1 each  0=MIR address, 1=IR address
DATAPATH_PIPE_ALUOperation_InBus  in  DATAWIDTH_ALU_SELECTION  ALU opcode
DATAPATH_PIPE_WriteEn_In  in  1  request write of C result this cycle
DATAPATH_PIPE_RD_In  in  1  C source = memory data (else ALU)
DATAPATH_PIPE_MemReady_In  in  1  memory data valid this cycle
DATAPATH_PIPE_MemoryData_InBus  in  DATAWIDTH_BUS  memory read data
DATAPATH_PIPE_A_OutBus / B_OutBus  out  DATAWIDTH_BUS each  bypassed read data (to ALU and memory address/data)
DATAPATH_PIPE_ALUData_OutBus  out  DATAWIDTH_BUS  combinational ALU result
DATAPATH_PIPE_FlagNegative_Out / FlagZero_Out / FlagOverflow_Out / FlagCarry_Out  out  1 each  registered PSR
DATAPATH_PIPE_Stall_Out  out  1  memory wait in progress

Behaviour:
- Single clock; every state element is reset synchronously by ResetInHigh at the rising edge.
- Reset values: r2..r(NUM_REGS-1)=0; WB valid=0; PSR NZVC=0000; Stall_Out=0 while reset is high.
- Address select: addrX = SelectX ? IRDirX : DirX.
- Reads:
  - combinational; r0=0, r1=FIXED_R1_VALUE;
  - address ≥NUM_REGS reads 0;
  - bypass: if WB valid and WB addr==read addr and addr≥2, output the WB data instead of the array value.
- ALU opcodes (package): 0 ANDCC, 1 ORCC, 2 NORCC, 3 ADDCC, 4 SRL (A>>B[4:0], logical), 5 AND, 6 OR, 7 NOR, 8 ADD, 9 LSHIFT2, 10 LSHIFT10, 11 SIMM13 (A[12:0] zero-extended), 12 SEXT13, 13 INC (A+1), 14 INCPC (A+4), 15 RSHIFT5 (A>>>5, arithmetic).
  - Add/inc ops are mod 2^DATAWIDTH_BUS.
- Flags:
  - Only ops 0..3 update the PSR, at the edge of a non-stalled cycle.
  - N=result MSB; Z=(result==0).
  - V and C come only from ADDCC: V=signed overflow, C=carry out. Logical cc ops clear V and C.
  - All other ops hold the PSR.
- Stall_Out = RD & ~MemReady (forced 0 in reset). While stalled: no WB capture, no PSR update. The controller holds all inputs until Stall_Out drops.
- Write-back stage (1-cycle latency):
  - At an edge with WriteEn=1, not stalled, and 2≤addrC<NUM_REGS: capture WB data = RD ? MemoryData : ALU result, plus WB addr, and set WB valid=1. Otherwise WB valid=0.
  - The array is written from WB at the following edge. The value is visible architecturally at the next cycle via bypass and at the cycle after from the array.
  - Writes to r0/r1 or out-of-range addresses are dropped silently.
- Simultaneous events:
  - A new WB capture and the array commit of the previous WB occur on the same edge. Same dest twice in a row yields the newer value.
  - A read of the address being committed gets the newer WB if it matches, else the committed value.
- Reset mid-stall or with WB valid: the pending write is discarded, not committed.

Decomposition:
- Package datapath_pipe_pkg holds the ALU opcode localparams (0..15), the index constants REG_ZERO=0 and REG_ONE=1, and a helper function flagging cc-updating ops.
- One sub-module is natural: datapath_pipe_alu (combinational, result plus NZVC). The register file, bypass, WB stage and PSR stay in the top module.

Test Plan:
1. Reset → A/B with DirA=0, DirB=1 read 0 and 1; flags 0000; Stall 0; r2..r37 read 0.
2. ADDCC A=r1, B=r1, WriteEn, DirC=5 → ALUData=2 same cycle; next cycle A reading r5 =2 (bypass); two cycles later =2 from array; flags N0 Z0 V0 C0.
3. Load r2=0x7FFFFFFF via RD with MemReady=1, then ADDCC r2+r1 → 0x80000000, flags N1 Z0 V1 C0. Then ORCC r0|r0 → Z1, V and C cleared.
4. RD=1, MemReady low for 3 cycles with data 0xDEADBEEF, dest r7 → Stall high exactly 3 cycles, no WB. MemReady high → r7 reads 0xDEADBEEF next cycle.
5. Writes to r0, r1 and addr 40 → reads remain 0, 1, 0. Then back-to-back writes 0x11 then 0x22 to r9 → r9 ends 0x22.
6. WB valid for r4=0x55 with reset asserted on the next edge → r4 reads 0. Also ADD (non-cc) after ADDCC leaves flags unchanged.

Source files
------------

// File: rtl/datapath_pipe_pkg.sv
// datapath_pipe_pkg: ALU opcodes, fixed register indices and cc-op helper
package datapath_pipe_pkg;
  localparam logic [3:0] ALU_ANDCC    = 4'd0;
  localparam logic [3:0] ALU_ORCC     = 4'd1;
  localparam logic [3:0] ALU_NORCC    = 4'd2;
  localparam logic [3:0] ALU_ADDCC    = 4'd3;
  localparam logic [3:0] ALU_SRL      = 4'd4;
  localparam logic [3:0] ALU_AND      = 4'd5;
  localparam logic [3:0] ALU_OR       = 4'd6;
  localparam logic [3:0] ALU_NOR      = 4'd7;
  localparam logic [3:0] ALU_ADD      = 4'd8;
  localparam logic [3:0] ALU_LSHIFT2  = 4'd9;
  localparam logic [3:0] ALU_LSHIFT10 = 4'd10;
  localparam logic [3:0] ALU_SIMM13   = 4'd11;
  localparam logic [3:0] ALU_SEXT13   = 4'd12;
  localparam logic [3:0] ALU_INC      = 4'd13;
  localparam logic [3:0] ALU_INCPC    = 4'd14;
  localparam logic [3:0] ALU_RSHIFT5  = 4'd15;
  localparam int REG_ZERO = 0;
  localparam int REG_ONE  = 1;
  function automatic logic is_cc_op(input logic [3:0] op);
    return op <= ALU_ADDCC;
  endfunction
endpackage

// File: rtl/datapath_pipe_alu.sv
// datapath_pipe_alu: combinational ARC ALU producing result and NZVC
//   a_i, b_i : operands      op_i   : opcode
//   y_o      : result        nzvc_o : flags (V/C only meaningful for ADDCC)
module datapath_pipe_alu
  import datapath_pipe_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [3:0]   op_i,
  output logic [W-1:0] y_o,
  output logic [3:0]   nzvc_o
);
  logic [W:0] sum;
  always_comb begin
    sum = {1'b0, a_i} + {1'b0, b_i};
    case (op_i)
      ALU_ANDCC, ALU_AND:  y_o = a_i & b_i;
      ALU_ORCC, ALU_OR:    y_o = a_i | b_i;
      ALU_NORCC, ALU_NOR:  y_o = ~(a_i | b_i);
      ALU_ADDCC, ALU_ADD:  y_o = sum[W-1:0];
      ALU_SRL:             y_o = a_i >> b_i[4:0];
      ALU_LSHIFT2:         y_o = a_i << 2;
      ALU_LSHIFT10:        y_o = a_i << 10;
      ALU_SIMM13:          y_o = {{(W-13){1'b0}}, a_i[12:0]};
      ALU_SEXT13:          y_o = {{(W-13){a_i[12]}}, a_i[12:0]};
      ALU_INC:             y_o = a_i + W'(1);
      ALU_INCPC:           y_o = a_i + W'(4);
      default:             y_o = $unsigned($signed(a_i) >>> 5);
    endcase
    nzvc_o = {y_o[W-1], y_o == '0,
              op_i == ALU_ADDCC && a_i[W-1] == b_i[W-1] && y_o[W-1] != a_i[W-1],
              op_i == ALU_ADDCC && sum[W]};
  end
endmodule

// File: rtl/datapath_pipe.sv
// datapath_pipe: register file with WB bypass, ARC ALU, PSR and memory-wait stall
//   Dir*/IRDir*/Select* : MIR or IR register addresses for ports A, B and dest C
//   ALUOperation        : ALU opcode       WriteEn/RD : write request, C from memory
//   MemReady/MemoryData : memory read handshake and data
//   A/B_OutBus          : bypassed reads   ALUData    : combinational ALU result
//   Flag*               : registered PSR   Stall      : memory wait in progress
module datapath_pipe
  import datapath_pipe_pkg::*;
#(
  parameter int DATAWIDTH_BUS           = 32,
  parameter int NUM_REGS                = 38,
  parameter int DATAWIDTH_REG_ADDR      = 6,
  parameter int DATAWIDTH_ALU_SELECTION = 4,
  parameter int FIXED_R1_VALUE          = 1
) (
  input  logic                               DATAPATH_PIPE_CLOCK_50,
  input  logic                               DATAPATH_PIPE_ResetInHigh_In,
  input  logic [DATAWIDTH_REG_ADDR-1:0]      DATAPATH_PIPE_DirA_InBus,
  input  logic [DATAWIDTH_REG_ADDR-1:0]      DATAPATH_PIPE_DirB_InBus,
  input  logic [DATAWIDTH_REG_ADDR-1:0]      DATAPATH_PIPE_DirC_InBus,
  input  logic [DATAWIDTH_REG_ADDR-1:0]      DATAPATH_PIPE_IRDirA_InBus,
  input  logic [DATAWIDTH_REG_ADDR-1:0]      DATAPATH_PIPE_IRDirB_InBus,
  input  logic [DATAWIDTH_REG_ADDR-1:0]      DATAPATH_PIPE_IRDirC_InBus,
  input  logic                               DATAPATH_PIPE_SelectA_In,
  input  logic                               DATAPATH_PIPE_SelectB_In,
  input  logic                               DATAPATH_PIPE_SelectC_In,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] DATAPATH_PIPE_ALUOperation_InBus,
  input  logic                               DATAPATH_PIPE_WriteEn_In,
  input  logic                               DATAPATH_PIPE_RD_In,
  input  logic                               DATAPATH_PIPE_MemReady_In,
  input  logic [DATAWIDTH_BUS-1:0]           DATAPATH_PIPE_MemoryData_InBus,
  output logic [DATAWIDTH_BUS-1:0]           DATAPATH_PIPE_A_OutBus,
  output logic [DATAWIDTH_BUS-1:0]           DATAPATH_PIPE_B_OutBus,
  output logic [DATAWIDTH_BUS-1:0]           DATAPATH_PIPE_ALUData_OutBus,
  output logic                               DATAPATH_PIPE_FlagNegative_Out,
  output logic                               DATAPATH_PIPE_FlagZero_Out,
  output logic                               DATAPATH_PIPE_FlagOverflow_Out,
  output logic                               DATAPATH_PIPE_FlagCarry_Out,
  output logic                               DATAPATH_PIPE_Stall_Out
);
  localparam int W  = DATAWIDTH_BUS;
  localparam int AW = DATAWIDTH_REG_ADDR;
  localparam logic [AW:0] NREGS = (AW+1)'(NUM_REGS);
  logic          rst;
  logic [AW-1:0] addr_a, addr_b, addr_c;
  logic [3:0]    op;
  logic          stall;
  logic [W-1:0]  regs_q [NUM_REGS];
  logic          wb_valid_q, wb_valid_d;
  logic [AW-1:0] wb_addr_q;
  logic [W-1:0]  wb_data_q, wb_data_d;
  logic [3:0]    psr_q, psr_d;
  logic [W-1:0]  alu_y;
  logic [3:0]    alu_nzvc;
  // wb fields are passed in so the continuous assigns stay sensitive to them
  function automatic logic [W-1:0] rd_port(input logic [AW-1:0] addr, input logic [W-1:0] arr,
                                           input logic wv, input logic [AW-1:0] wa,
                                           input logic [W-1:0] wd);
    return addr == AW'(REG_ZERO) ? '0 :
           addr == AW'(REG_ONE) ? W'(FIXED_R1_VALUE) :
           {1'b0, addr} >= NREGS ? '0 :
           (wv && wa == addr) ? wd : arr;
  endfunction
  assign rst    = DATAPATH_PIPE_ResetInHigh_In;
  assign op     = 4'(DATAPATH_PIPE_ALUOperation_InBus);
  assign addr_a = DATAPATH_PIPE_SelectA_In ? DATAPATH_PIPE_IRDirA_InBus : DATAPATH_PIPE_DirA_InBus;
  assign addr_b = DATAPATH_PIPE_SelectB_In ? DATAPATH_PIPE_IRDirB_InBus : DATAPATH_PIPE_DirB_InBus;
  assign addr_c = DATAPATH_PIPE_SelectC_In ? DATAPATH_PIPE_IRDirC_InBus : DATAPATH_PIPE_DirC_InBus;
  assign stall  = DATAPATH_PIPE_RD_In & ~DATAPATH_PIPE_MemReady_In & ~rst;
  assign DATAPATH_PIPE_A_OutBus = rd_port(addr_a, regs_q[addr_a], wb_valid_q, wb_addr_q, wb_data_q);
  assign DATAPATH_PIPE_B_OutBus = rd_port(addr_b, regs_q[addr_b], wb_valid_q, wb_addr_q, wb_data_q);
  datapath_pipe_alu #(.W(W)) u_alu (
    .a_i   (DATAPATH_PIPE_A_OutBus),
    .b_i   (DATAPATH_PIPE_B_OutBus),
    .op_i  (op),
    .y_o   (alu_y),
    .nzvc_o(alu_nzvc)
  );
  assign DATAPATH_PIPE_ALUData_OutBus = alu_y;
  // only r2..r(NUM_REGS-1) are writable; other destinations never enter WB
  assign wb_valid_d = DATAPATH_PIPE_WriteEn_In & ~stall & (addr_c > AW'(REG_ONE)) & ({1'b0, addr_c} < NREGS);
  assign wb_data_d  = DATAPATH_PIPE_RD_In ? DATAPATH_PIPE_MemoryData_InBus : alu_y;
  assign psr_d      = (~stall & is_cc_op(op)) ? alu_nzvc : psr_q;
  always_ff @(posedge DATAPATH_PIPE_CLOCK_50) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      psr_q      <= '0;
    end else begin
      if (wb_valid_q) regs_q[wb_addr_q] <= wb_data_q;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= addr_c;
      wb_data_q  <= wb_data_d;
      psr_q      <= psr_d;
    end
  end
  assign {DATAPATH_PIPE_FlagNegative_Out, DATAPATH_PIPE_FlagZero_Out,
          DATAPATH_PIPE_FlagOverflow_Out, DATAPATH_PIPE_FlagCarry_Out} = psr_q;
  assign DATAPATH_PIPE_Stall_Out = stall;
endmodule

// File: tb/tb_datapath_pipe.sv
// tb_datapath_pipe: directed self-checking bench for datapath_pipe
module tb_datapath_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  dir_a = '0, dir_b = '0, dir_c = '0, ir_a = '0, ir_b = '0, ir_c = '0;
  logic        sel_a = 1'b0, sel_b = 1'b0, sel_c = 1'b0;
  logic [3:0]  op = 4'd8;
  logic        we = 1'b0, rd = 1'b0, mr = 1'b0;
  logic [31:0] md = '0;
  logic [31:0] a_out, b_out, alu_out;
  logic        fn, fz, fv, fc, stall;
  logic [3:0]  flags;
  int          vecs = 0;
  int          errs = 0;
  logic [31:0] exp_r2 [16] = '{32'h1, 32'h7FFFFFFF, 32'h80000000, 32'h80000000,
                               32'h3FFFFFFF, 32'h1, 32'h7FFFFFFF, 32'h80000000,
                               32'h80000000, 32'hFFFFFFFC, 32'hFFFFFC00, 32'h00001FFF,
                               32'hFFFFFFFF, 32'h80000000, 32'h80000003, 32'h03FFFFFF};
  logic [31:0] exp_r7 [16] = '{32'h1, 32'hDEADBEEF, 32'h21524110, 32'hDEADBEF0,
                               32'h6F56DF77, 32'h1, 32'hDEADBEEF, 32'h21524110,
                               32'hDEADBEF0, 32'h7AB6FBBC, 32'hB6FBBC00, 32'h00001EEF,
                               32'hFFFFFEEF, 32'hDEADBEF0, 32'hDEADBEF3, 32'hFEF56DF7};
  assign flags = {fn, fz, fv, fc};
  always #5 clk = ~clk;
  datapath_pipe dut (
    .DATAPATH_PIPE_CLOCK_50          (clk),
    .DATAPATH_PIPE_ResetInHigh_In    (rst),
    .DATAPATH_PIPE_DirA_InBus        (dir_a),
    .DATAPATH_PIPE_DirB_InBus        (dir_b),
    .DATAPATH_PIPE_DirC_InBus        (dir_c),
    .DATAPATH_PIPE_IRDirA_InBus      (ir_a),
    .DATAPATH_PIPE_IRDirB_InBus      (ir_b),
    .DATAPATH_PIPE_IRDirC_InBus      (ir_c),
    .DATAPATH_PIPE_SelectA_In        (sel_a),
    .DATAPATH_PIPE_SelectB_In        (sel_b),
    .DATAPATH_PIPE_SelectC_In        (sel_c),
    .DATAPATH_PIPE_ALUOperation_InBus(op),
    .DATAPATH_PIPE_WriteEn_In        (we),
    .DATAPATH_PIPE_RD_In             (rd),
    .DATAPATH_PIPE_MemReady_In       (mr),
    .DATAPATH_PIPE_MemoryData_InBus  (md),
    .DATAPATH_PIPE_A_OutBus          (a_out),
    .DATAPATH_PIPE_B_OutBus          (b_out),
    .DATAPATH_PIPE_ALUData_OutBus    (alu_out),
    .DATAPATH_PIPE_FlagNegative_Out  (fn),
    .DATAPATH_PIPE_FlagZero_Out      (fz),
    .DATAPATH_PIPE_FlagOverflow_Out  (fv),
    .DATAPATH_PIPE_FlagCarry_Out     (fc),
    .DATAPATH_PIPE_Stall_Out         (stall)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1; rd = 1'b1; mr = 1'b0;
    tick(); tick();
    #1; vecs++;
    if (stall !== 1'b0) begin errs++; $display("FAIL rst_stall got %b want 0", stall); end
    rst = 1'b0; rd = 1'b0;
    dir_a = 6'd0; dir_b = 6'd1;
    #1; vecs++;
    if (a_out !== 32'd0) begin errs++; $display("FAIL rst_r0 got %h want 0", a_out); end
    vecs++;
    if (b_out !== 32'd1) begin errs++; $display("FAIL rst_r1 got %h want 1", b_out); end
    vecs++;
    if (flags !== 4'b0000) begin errs++; $display("FAIL rst_flags got %b want 0000", flags); end
    vecs++;
    if (stall !== 1'b0) begin errs++; $display("FAIL rst_stall_rel got %b want 0", stall); end
    for (int i = 2; i < 38; i++) begin
      dir_a = 6'(i);
      #1; vecs++;
      if (a_out !== 32'd0) begin errs++; $display("FAIL rst_r%0d got %h want 0", i, a_out); end
    end
  endtask
  task automatic test_addcc();
    dir_a = 6'd1; dir_b = 6'd1; op = 4'd3; we = 1'b1; dir_c = 6'd5;
    #1; vecs++;
    if (alu_out !== 32'd2) begin errs++; $display("FAIL addcc_alu got %h want 2", alu_out); end
    tick();
    we = 1'b0; op = 4'd8; dir_a = 6'd5;
    #1; vecs++;
    if (a_out !== 32'd2) begin errs++; $display("FAIL addcc_bypass got %h want 2", a_out); end
    vecs++;
    if (flags !== 4'b0000) begin errs++; $display("FAIL addcc_flags got %b want 0000", flags); end
    tick(); #1; vecs++;
    if (a_out !== 32'd2) begin errs++; $display("FAIL addcc_array got %h want 2", a_out); end
  endtask
  task automatic test_flags();
    rd = 1'b1; mr = 1'b1; we = 1'b1; dir_c = 6'd2; md = 32'h7FFFFFFF; op = 4'd8;
    tick();
    rd = 1'b0; we = 1'b0; op = 4'd3; dir_a = 6'd2; dir_b = 6'd1;
    #1; vecs++;
    if (alu_out !== 32'h80000000) begin errs++; $display("FAIL ovf_alu got %h want 80000000", alu_out); end
    tick(); vecs++;
    if (flags !== 4'b1010) begin errs++; $display("FAIL ovf_flags got %b want 1010", flags); end
    op = 4'd1; dir_a = 6'd0; dir_b = 6'd0;
    tick(); vecs++;
    if (flags !== 4'b0100) begin errs++; $display("FAIL orcc_flags got %b want 0100", flags); end
    op = 4'd7; we = 1'b1; dir_c = 6'd3;
    tick();
    we = 1'b0; op = 4'd3; dir_a = 6'd3; dir_b = 6'd1;
    #1; vecs++;
    if (alu_out !== 32'd0) begin errs++; $display("FAIL carry_alu got %h want 0", alu_out); end
    tick(); vecs++;
    if (flags !== 4'b0101) begin errs++; $display("FAIL carry_flags got %b want 0101", flags); end
    op = 4'd8; dir_a = 6'd1; dir_b = 6'd1;
    tick(); tick(); vecs++;
    if (flags !== 4'b0101) begin errs++; $display("FAIL add_hold got %b want 0101", flags); end
  endtask
  task automatic test_stall();
    sel_a = 1'b1; ir_a = 6'd7; dir_a = 6'd0; dir_b = 6'd0; op = 4'd1;
    rd = 1'b1; mr = 1'b0; we = 1'b1; dir_c = 6'd7; md = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      #1; vecs++;
      if (stall !== 1'b1) begin errs++; $display("FAIL stall_c%0d got %b want 1", i, stall); end
      vecs++;
      if (a_out !== 32'd0) begin errs++; $display("FAIL stall_nowb_c%0d got %h want 0", i, a_out); end
      tick(); vecs++;
      if (flags !== 4'b0101) begin errs++; $display("FAIL stall_psr_c%0d got %b want 0101", i, flags); end
    end
    mr = 1'b1;
    #1; vecs++;
    if (stall !== 1'b0) begin errs++; $display("FAIL stall_drop got %b want 0", stall); end
    tick();
    rd = 1'b0; mr = 1'b0; we = 1'b0; op = 4'd8;
    #1; vecs++;
    if (a_out !== 32'hDEADBEEF) begin errs++; $display("FAIL stall_r7 got %h want deadbeef", a_out); end
    vecs++;
    if (flags !== 4'b0100) begin errs++; $display("FAIL stall_release_psr got %b want 0100", flags); end
    sel_a = 1'b0;
  endtask
  task automatic test_alu_ops();
    dir_b = 6'd1;
    for (int i = 0; i < 16; i++) begin
      op = 4'(i); dir_a = 6'd2;
      #1; vecs++;
      if (alu_out !== exp_r2[i]) begin errs++; $display("FAIL alu_r2_op%0d got %h want %h", i, alu_out, exp_r2[i]); end
      dir_a = 6'd7;
      #1; vecs++;
      if (alu_out !== exp_r7[i]) begin errs++; $display("FAIL alu_r7_op%0d got %h want %h", i, alu_out, exp_r7[i]); end
    end
    op = 4'd8;
  endtask
  task automatic test_dropped();
    logic [5:0] dests [5] = '{6'd0, 6'd1, 6'd40, 6'd38, 6'd37};
    op = 4'd8; dir_a = 6'd1; dir_b = 6'd1; we = 1'b1;
    foreach (dests[i]) begin
      dir_c = dests[i];
      tick();
    end
    we = 1'b0;
    tick();
    dir_a = 6'd0; dir_b = 6'd1;
    #1; vecs++;
    if (a_out !== 32'd0) begin errs++; $display("FAIL drop_r0 got %h want 0", a_out); end
    vecs++;
    if (b_out !== 32'd1) begin errs++; $display("FAIL drop_r1 got %h want 1", b_out); end
    dir_a = 6'd40; dir_b = 6'd38;
    #1; vecs++;
    if (a_out !== 32'd0) begin errs++; $display("FAIL drop_r40 got %h want 0", a_out); end
    vecs++;
    if (b_out !== 32'd0) begin errs++; $display("FAIL drop_r38 got %h want 0", b_out); end
    dir_a = 6'd37;
    #1; vecs++;
    if (a_out !== 32'd2) begin errs++; $display("FAIL write_r37 got %h want 2", a_out); end
  endtask
  task automatic test_back_to_back();
    sel_c = 1'b1; ir_c = 6'd9; dir_c = 6'd0; dir_a = 6'd9;
    rd = 1'b1; mr = 1'b1; we = 1'b1; md = 32'h11;
    tick(); vecs++;
    if (a_out !== 32'h11) begin errs++; $display("FAIL b2b_first got %h want 11", a_out); end
    md = 32'h22;
    tick();
    rd = 1'b0; mr = 1'b0; we = 1'b0; sel_c = 1'b0;
    #1; vecs++;
    if (a_out !== 32'h22) begin errs++; $display("FAIL b2b_bypass got %h want 22", a_out); end
    tick(); vecs++;
    if (a_out !== 32'h22) begin errs++; $display("FAIL b2b_array got %h want 22", a_out); end
  endtask
  task automatic test_reset_wb();
    rd = 1'b1; mr = 1'b1; we = 1'b1; dir_c = 6'd4; md = 32'h55; dir_a = 6'd4;
    tick(); vecs++;
    if (a_out !== 32'h55) begin errs++; $display("FAIL rwb_bypass got %h want 55", a_out); end
    rd = 1'b0; mr = 1'b0; we = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1; vecs++;
    if (a_out !== 32'd0) begin errs++; $display("FAIL rwb_r4 got %h want 0", a_out); end
    vecs++;
    if (flags !== 4'b0000) begin errs++; $display("FAIL rwb_flags got %b want 0000", flags); end
    tick(); vecs++;
    if (a_out !== 32'd0) begin errs++; $display("FAIL rwb_r4_late got %h want 0", a_out); end
  endtask
  initial begin
    test_reset();
    test_addcc();
    test_flags();
    test_stall();
    test_alu_ops();
    test_dropped();
    test_back_to_back();
    test_reset_wb();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
